dispatch_ctrl: RTL and testbench

In-order dispatch controller between the fetch stage and rename/dispatch. It buffers fetched instructions in a small FIFO and presents the head entry to the instruction decoder. Using the decoder's results and back-end resource availability, it decides each cycle whether the head instruction dispatches. It also sequences halt and illegal-instruction shutdown, and flushes on branch-mispredict squash.

---
 rtl/dispatch_ctrl_pkg.sv | 49 ++++
 rtl/dispatch_ctrl_inst_fifo.sv | 63 ++++++
 rtl/dispatch_ctrl.sv | 119 +++++++++++
 tb/tb_dispatch_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types for the fetch/decode/dispatch front end.
// Holds the FU select, fetch packet, dispatch FSM states and RS class map.
package dispatch_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SHIFT,
        MULT_LO,
        MULT_HI,
        BRANCH,
        LS_LOAD,
        LS_STORE
    } FU_SELECT;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } IF_ID_PACKET;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } DISPATCH_STATE;

    localparam logic [1:0] RS_ALU  = 2'd0;
    localparam logic [1:0] RS_MULT = 2'd1;
    localparam logic [1:0] RS_BR   = 2'd2;
    localparam logic [1:0] RS_LS   = 2'd3;

    function automatic logic [1:0] rs_class(input FU_SELECT fu);
        logic [1:0] c;
        unique case (fu)
            MULT_LO, MULT_HI:  c = RS_MULT;
            BRANCH:            c = RS_BR;
            LS_LOAD, LS_STORE: c = RS_LS;
            default:           c = RS_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dispatch_ctrl_inst_fifo.sv
// Circular instruction buffer between fetch and dispatch.
// Extra pointer MSB separates full from empty; head.valid tracks non-empty.
module inst_fifo
    import dispatch_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  IF_ID_PACKET din,
    output IF_ID_PACKET head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    IF_ID_PACKET mem_q [DEPTH];

    // Next pointers: flush returns both to zero and beats any push/pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; contents need no reset since valid comes from the pointers
    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

    // Status flags and head presentation
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) &&
                (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        head  = mem_q[rptr_q[AW-1:0]];
        head.valid = !empty;
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order dispatch controller: buffers fetch, gates the head on resources,
// sequences halt/illegal drain and flushes on mispredict squash.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int IQ_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  IF_ID_PACKET if_pkt,
    output logic        if_ready,
    output IF_ID_PACKET dec_pkt,
    input  FU_SELECT    dec_fu_unit_sel,
    input  logic [4:0]  dec_dst_arch_reg,
    input  logic        dec_halt,
    input  logic        dec_illegal,
    input  logic        dec_is_store,
    input  logic        rob_avail,
    input  logic        rob_empty,
    input  logic [3:0]  rs_avail,
    input  logic        fl_avail,
    input  logic        sq_avail,
    input  logic        squash,
    output logic        dispatch_valid,
    output logic        halted,
    output logic        illegal_trap,
    output logic [31:0] stall_cycles
);

    DISPATCH_STATE state_q;
    logic          halted_q;
    logic          illegal_q;
    logic [31:0]   stall_q, stall_d;

    logic       fifo_full, fifo_empty;
    logic       push, flush;
    logic [1:0] cls;
    logic       res_ok, go, in_run;

    inst_fifo #(.DEPTH(IQ_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (dispatch_valid),
        .flush (flush),
        .din   (if_pkt),
        .head  (dec_pkt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake and dispatch gating for the head instruction
    always_comb begin
        in_run   = (state_q == RUN);
        if_ready = !fifo_full && in_run;
        flush    = squash && (state_q != HALTED);
        push     = if_valid && if_ready && !flush;
        cls      = rs_class(dec_fu_unit_sel);
        res_ok   = rob_avail && rs_avail[cls] &&
                   (dec_dst_arch_reg == 5'd0 || fl_avail) &&
                   (!dec_is_store || sq_avail);
        go       = (dec_halt || dec_illegal) ? rob_avail : res_ok;
        dispatch_valid = in_run && !fifo_empty && !squash && go;
    end

    // Halt/illegal sequencing with registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dispatch_valid && (dec_halt || dec_illegal)) begin
                        state_q   <= DRAIN;
                        illegal_q <= dec_illegal;
                    end
                end
                DRAIN: begin
                    if (squash) begin
                        state_q   <= RUN;
                        illegal_q <= 1'b0;
                    end else if (rob_empty) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Saturating count of RUN cycles where a queued head could not go
    always_comb begin
        stall_d = stall_q;
        if (in_run && !fifo_empty && !dispatch_valid && !squash &&
            stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign halted       = halted_q;
    assign illegal_trap = illegal_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with a tiny RV32 decoder model.
// Covers streaming, free-list stall, full FIFO, halt, squash and async reset.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        if_valid;
    IF_ID_PACKET if_pkt;
    logic        if_ready;
    IF_ID_PACKET dec_pkt;
    FU_SELECT    dec_fu_unit_sel;
    logic [4:0]  dec_dst_arch_reg;
    logic        dec_halt;
    logic        dec_illegal;
    logic        dec_is_store;
    logic        rob_avail;
    logic        rob_empty;
    logic [3:0]  rs_avail;
    logic        fl_avail;
    logic        sq_avail;
    logic        squash;
    logic        dispatch_valid;
    logic        halted;
    logic        illegal_trap;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] WFI     = 32'h1050_0073;
    localparam logic [31:0] ILL     = 32'h0000_0000;
    localparam logic [31:0] ADD_X5  = 32'h0020_82b3;
    localparam logic [31:0] ADD_X0  = 32'h0020_8033;

    dispatch_ctrl #(.IQ_DEPTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .if_valid         (if_valid),
        .if_pkt           (if_pkt),
        .if_ready         (if_ready),
        .dec_pkt          (dec_pkt),
        .dec_fu_unit_sel  (dec_fu_unit_sel),
        .dec_dst_arch_reg (dec_dst_arch_reg),
        .dec_halt         (dec_halt),
        .dec_illegal      (dec_illegal),
        .dec_is_store     (dec_is_store),
        .rob_avail        (rob_avail),
        .rob_empty        (rob_empty),
        .rs_avail         (rs_avail),
        .fl_avail         (fl_avail),
        .sq_avail         (sq_avail),
        .squash           (squash),
        .dispatch_valid   (dispatch_valid),
        .halted           (halted),
        .illegal_trap     (illegal_trap),
        .stall_cycles     (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Minimal decoder for the head instruction
    always_comb begin
        dec_fu_unit_sel  = ALU_ADD;
        dec_dst_arch_reg = 5'd0;
        dec_halt         = 1'b0;
        dec_illegal      = 1'b0;
        dec_is_store     = 1'b0;
        case (dec_pkt.inst[6:0])
            7'h13: dec_dst_arch_reg = dec_pkt.inst[11:7];
            7'h33: begin
                dec_dst_arch_reg = dec_pkt.inst[11:7];
                dec_fu_unit_sel  = dec_pkt.inst[25] ? MULT_LO : ALU_ADD;
            end
            7'h03: begin
                dec_dst_arch_reg = dec_pkt.inst[11:7];
                dec_fu_unit_sel  = LS_LOAD;
            end
            7'h23: begin
                dec_fu_unit_sel = LS_STORE;
                dec_is_store    = 1'b1;
            end
            7'h63: dec_fu_unit_sel = BRANCH;
            7'h73: begin
                if (dec_pkt.inst == WFI) dec_halt = 1'b1;
                else                     dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    function automatic IF_ID_PACKET mk(input logic [31:0] inst,
                                       input logic [31:0] pc);
        IF_ID_PACKET p;
        p.inst  = inst;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        if_valid  = 1'b0;
        if_pkt    = '0;
        rob_avail = 1'b1;
        rob_empty = 1'b0;
        rs_avail  = 4'hF;
        fl_avail  = 1'b1;
        sq_avail  = 1'b1;
        squash    = 1'b0;
        #12;
        check("rst_if_ready", 32'(if_ready), 32'd1);
        check("rst_disp", 32'(dispatch_valid), 32'd0);
        check("rst_dec_valid", 32'(dec_pkt.valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal_trap), 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        reset = 1'b0;
        tick();

        // Streaming: ADDI x1..x4 one per cycle
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1;
            if_pkt   = mk(32'h0000_0013 | (32'(i + 1) << 7), 32'h100 + 32'(4 * i));
            #1;
            if (i == 0) check("stream_first_nodisp", 32'(dispatch_valid), 32'd0);
            else begin
                check("stream_disp", 32'(dispatch_valid), 32'd1);
                check("stream_pc", dec_pkt.PC, 32'h100 + 32'(4 * (i - 1)));
            end
            tick();
        end
        if_valid = 1'b0;
        #1;
        check("stream_disp_last", 32'(dispatch_valid), 32'd1);
        check("stream_pc_last", dec_pkt.PC, 32'h10C);
        tick();
        check("stream_empty", 32'(dec_pkt.valid), 32'd0);
        check("stream_stall", stall_cycles, 32'd0);

        // Free-list stall on ADD x5
        fl_avail = 1'b0;
        if_valid = 1'b1;
        if_pkt   = mk(ADD_X5, 32'h200);
        tick();
        if_valid = 1'b0;
        #1;
        check("fl_nodisp", 32'(dispatch_valid), 32'd0);
        tick();
        tick();
        tick();
        check("fl_stall3", stall_cycles, 32'd3);
        fl_avail = 1'b1;
        #1;
        check("fl_disp", 32'(dispatch_valid), 32'd1);
        tick();
        check("fl_stall_hold", stall_cycles, 32'd3);
        fl_avail = 1'b0;
        if_valid = 1'b1;
        if_pkt   = mk(ADD_X0, 32'h204);
        tick();
        if_valid = 1'b0;
        #1;
        check("x0_disp", 32'(dispatch_valid), 32'd1);
        tick();
        fl_avail = 1'b1;

        // Full FIFO: 8 pushes with the ROB blocked
        rob_avail = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if_valid = 1'b1;
            if_pkt   = mk(32'h0000_0013 | (32'(i + 1) << 7), 32'h300 + 32'(4 * i));
            tick();
        end
        check("full_not_ready", 32'(if_ready), 32'd0);
        check("full_stall", stall_cycles, 32'd10);
        if_pkt    = mk(32'h0000_0013, 32'h320);
        rob_avail = 1'b1;
        #1;
        check("full_pop_not_ready", 32'(if_ready), 32'd0);
        check("full_pop_disp", 32'(dispatch_valid), 32'd1);
        tick();
        rob_avail = 1'b0;
        #1;
        check("full_ready_after", 32'(if_ready), 32'd1);
        tick();
        check("full_again", 32'(if_ready), 32'd0);
        if_valid  = 1'b0;
        rob_avail = 1'b1;
        for (int i = 1; i < 9; i++) begin
            #1;
            check("full_order", dec_pkt.PC, 32'h300 + 32'(4 * i));
            tick();
        end
        check("full_drained", 32'(dec_pkt.valid), 32'd0);

        // Halt via WFI while the ROB is still busy
        if_valid = 1'b1;
        if_pkt   = mk(WFI, 32'h400);
        tick();
        if_valid = 1'b0;
        #1;
        check("wfi_disp", 32'(dispatch_valid), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("drain_not_ready", 32'(if_ready), 32'd0);
            check("drain_halted", 32'(halted), 32'd0);
            tick();
        end
        rob_empty = 1'b1;
        tick();
        check("halted", 32'(halted), 32'd1);
        check("halt_no_trap", 32'(illegal_trap), 32'd0);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        check("halted_sticky", 32'(halted), 32'd1);
        check("halted_not_ready", 32'(if_ready), 32'd0);

        reset = 1'b1;
        #1;
        reset     = 1'b0;
        rob_empty = 1'b0;
        tick();
        check("rst2_stall", stall_cycles, 32'd0);

        // Squash in DRAIN after an illegal instruction with 3 queued
        rob_avail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1;
            if_pkt   = mk(i == 0 ? ILL : 32'h0000_0093, 32'h500 + 32'(4 * i));
            tick();
        end
        if_valid  = 1'b0;
        rob_avail = 1'b1;
        #1;
        check("ill_disp", 32'(dispatch_valid), 32'd1);
        tick();
        check("ill_trap", 32'(illegal_trap), 32'd1);
        check("ill_queued", 32'(dec_pkt.valid), 32'd1);
        check("ill_not_ready", 32'(if_ready), 32'd0);
        check("ill_stall", stall_cycles, 32'd3);
        squash   = 1'b1;
        if_valid = 1'b1;
        if_pkt   = mk(32'h0000_0093, 32'h600);
        tick();
        squash   = 1'b0;
        if_valid = 1'b0;
        check("sq_empty", 32'(dec_pkt.valid), 32'd0);
        check("sq_run", 32'(if_ready), 32'd1);
        check("sq_trap_clr", 32'(illegal_trap), 32'd0);
        tick();
        check("sq_discard", 32'(dec_pkt.valid), 32'd0);

        // Reset asserted mid-drain, checked before any clock edge
        if_valid = 1'b1;
        if_pkt   = mk(ILL, 32'h700);
        tick();
        if_pkt = mk(32'h0000_0093, 32'h704);
        tick();
        if_valid = 1'b0;
        check("md_trap", 32'(illegal_trap), 32'd1);
        check("md_queued", 32'(dec_pkt.valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("md_if_ready", 32'(if_ready), 32'd1);
        check("md_dec_valid", 32'(dec_pkt.valid), 32'd0);
        check("md_disp", 32'(dispatch_valid), 32'd0);
        check("md_trap_clr", 32'(illegal_trap), 32'd0);
        check("md_halted", 32'(halted), 32'd0);
        check("md_stall", stall_cycles, 32'd0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
